// File: rtl/flash_sequencer_if.sv
// Bundle between the flash sequencer and its next-state generator.
// The generator side is the master; the sequencer is the slave.
interface flash_sequencer_if;
  logic        flick;
  logic [2:0]  main_state_n;
  logic [4:0]  counter_load;
  logic        counter_load_en;
  logic [1:0]  count_state;
  logic [2:0]  main_state;
  logic [4:0]  counter;
  logic        flick_sync;
  logic        kickback_match;
  logic        step_tick;
  logic [15:0] leds;

  modport master (
    output flick, main_state_n, counter_load, counter_load_en, count_state,
    input  main_state, counter, flick_sync, kickback_match, step_tick, leds
  );

  modport slave (
    input  flick, main_state_n, counter_load, counter_load_en, count_state,
    output main_state, counter, flick_sync, kickback_match, step_tick, leds
  );
endinterface

// File: rtl/flash_sequencer.sv
// Registered state/counter datapath for the LED flash sequence: flick synchronizer,
// step prescaler, saturating step counter, kickback detect and thermometer LED drive.
module flash_sequencer #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  flash_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    ONLED0_15  = 3'd1,
    OFFLED15_5 = 3'd2,
    ONLED5_10  = 3'd3,
    OFFLED10_0 = 3'd4,
    ONLED0_5   = 3'd5,
    OFFLED5_0  = 3'd6,
    ILLEGAL    = 3'd7
  } main_state_e;

  typedef enum logic [1:0] {
    CNT_OFF  = 2'd0,
    CNT_UP   = 2'd1,
    CNT_DOWN = 2'd2,
    CNT_OFF3 = 2'd3
  } count_mode_e;

  localparam logic [7:0] PRESC_MAX = 8'(STEP_DIV - 1);

  main_state_e main_state_q, main_state_d;
  logic [4:0]  counter_q, counter_d;
  logic [7:0]  presc_q, presc_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        step_tick;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_state_q <= INIT;
      counter_q    <= '0;
      presc_q      <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      main_state_q <= main_state_d;
      counter_q    <= counter_d;
      presc_q      <= presc_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
    end
  end

  // Tick is suppressed while reset is held so nothing downstream sees a step.
  assign step_tick = !rst && (presc_q == PRESC_MAX);

  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    presc_d      = (presc_q == PRESC_MAX) ? 8'd0 : presc_q + 8'd1;
    sync1_d      = bus.flick;
    sync2_d      = sync1_q;
    main_state_d = main_state_q;
    counter_d    = counter_q;

    if (step_tick) begin
      main_state_d = main_state_e'(bus.main_state_n);
      if (bus.counter_load_en) begin
        counter_d = bus.counter_load;
      end else begin
        unique case (count_mode_e'(bus.count_state))
          CNT_UP:   counter_d = (counter_q == 5'd31) ? counter_q : counter_q + 5'd1;
          CNT_DOWN: counter_d = (counter_q == 5'd0)  ? counter_q : counter_q - 5'd1;
          default:  counter_d = counter_q;
        endcase
      end
    end
  end

  always_comb begin
    bus.leds = '0;
    if (main_state_q != INIT && main_state_q != ILLEGAL) begin
      for (int i = 0; i < 16; i++) begin
        bus.leds[i] = (5'(i) < counter_q);
      end
    end
  end

  assign bus.kickback_match = sync2_q &&
                              ((main_state_q == OFFLED15_5 && counter_q == 5'd5) ||
                               (main_state_q == OFFLED10_0 && counter_q == 5'd0));

  assign bus.main_state = main_state_q;
  assign bus.counter    = counter_q;
  assign bus.flick_sync = sync2_q;
  assign bus.step_tick  = step_tick;

endmodule

// File: tb/tb_flash_sequencer.sv
// Bench: closed-loop run of a STEP_DIV=1 sequencer with a next-state generator, plus
// a STEP_DIV=4 instance under random stimulus against a behavioural model.
module tb_flash_sequencer;

  localparam int SD_R = 4;

  logic clk;
  logic rst_g;
  logic rst_r;

  int total = 0;
  int bad   = 0;

  flash_sequencer_if bus1 ();
  flash_sequencer_if bus4 ();

  flash_sequencer #(.STEP_DIV(1)) dut_g (
    .clk (clk),
    .rst (rst_g),
    .bus (bus1)
  );

  flash_sequencer #(.STEP_DIV(SD_R)) dut_r (
    .clk (clk),
    .rst (rst_r),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] therm(input int ms, input int c);
    if (ms == 0 || ms == 7) return 16'h0000;
    if (c >= 16) return 16'hFFFF;
    return 16'((32'd1 << c) - 32'd1);
  endfunction

  // Next-state generator for the closed-loop instance.
  logic       gen_mode;
  logic [2:0] g_ms_n, t_ms_n;
  logic [4:0] g_load, t_load;
  logic       g_len, t_len;
  logic [1:0] g_cs, t_cs;

  always_comb begin
    g_ms_n = bus1.main_state;
    g_load = 5'd0;
    g_len  = 1'b0;
    g_cs   = 2'd0;
    case (bus1.main_state)
      3'd0: if (bus1.flick_sync) g_ms_n = 3'd1;
      3'd1: if (bus1.counter == 5'd16) begin g_ms_n = 3'd2; g_cs = 2'd2; end
            else g_cs = 2'd1;
      3'd2: if (bus1.kickback_match) begin g_len = 1'b1; g_load = 5'd16; end
            else if (bus1.counter == 5'd5) begin g_ms_n = 3'd3; g_cs = 2'd1; end
            else g_cs = 2'd2;
      3'd3: if (bus1.counter == 5'd11) begin g_ms_n = 3'd4; g_cs = 2'd2; end
            else g_cs = 2'd1;
      3'd4: if (bus1.kickback_match) begin g_len = 1'b1; g_load = 5'd11; end
            else if (bus1.counter == 5'd0) begin g_ms_n = 3'd5; g_cs = 2'd1; end
            else g_cs = 2'd2;
      3'd5: if (bus1.counter == 5'd6) begin g_ms_n = 3'd6; g_cs = 2'd2; end
            else g_cs = 2'd1;
      3'd6: if (bus1.counter == 5'd0) g_ms_n = 3'd0;
            else g_cs = 2'd2;
      default: begin g_ms_n = 3'd0; g_len = 1'b1; end
    endcase
  end

  always_comb begin
    if (gen_mode) begin
      bus1.main_state_n    = g_ms_n;
      bus1.counter_load    = g_load;
      bus1.counter_load_en = g_len;
      bus1.count_state     = g_cs;
    end else begin
      bus1.main_state_n    = t_ms_n;
      bus1.counter_load    = t_load;
      bus1.counter_load_en = t_len;
      bus1.count_state     = t_cs;
    end
  end

  typedef struct {
    logic        len;
    logic [4:0]  load;
    logic [1:0]  cs;
    logic [2:0]  ms_n;
    logic [2:0]  exp_ms;
    logic [4:0]  exp_cnt;
    logic [15:0] exp_leds;
    logic        exp_kick;
  } vec_t;

  task automatic start_sequence();
    bus1.flick = 1'b1;
    repeat (3) tick();
    bus1.flick = 1'b0;
  endtask

  // Closed-loop and table-driven checks on the STEP_DIV=1 instance.
  task automatic run_gen();
    vec_t vecs[14];
    int   visits[$];
    int   peak[8];
    int   lo[8];
    int   n;
    bit   done;
    int   prev;
    int   exp_visits[7];

    vecs[0]  = '{1'b0, 5'd0,  2'd2, 3'd1, 3'd1, 5'd0,  16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 5'd7,  2'd1, 3'd3, 3'd3, 5'd7,  16'h007F, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  2'd1, 3'd3, 3'd3, 5'd8,  16'h00FF, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  2'd3, 3'd3, 3'd3, 5'd8,  16'h00FF, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  2'd0, 3'd2, 3'd2, 5'd8,  16'h00FF, 1'b0};
    vecs[5]  = '{1'b1, 5'd31, 2'd0, 3'd5, 3'd5, 5'd31, 16'hFFFF, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  2'd1, 3'd5, 3'd5, 5'd31, 16'hFFFF, 1'b0};
    vecs[7]  = '{1'b1, 5'd16, 2'd2, 3'd1, 3'd1, 5'd16, 16'hFFFF, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  2'd2, 3'd1, 3'd1, 5'd15, 16'h7FFF, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  2'd0, 3'd7, 3'd7, 5'd15, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 5'd0,  2'd0, 3'd6, 3'd6, 5'd0,  16'h0000, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  2'd1, 3'd0, 3'd0, 5'd1,  16'h0000, 1'b0};
    vecs[12] = '{1'b1, 5'd5,  2'd0, 3'd2, 3'd2, 5'd5,  16'h001F, 1'b0};
    vecs[13] = '{1'b1, 5'd0,  2'd0, 3'd4, 3'd4, 5'd0,  16'h0000, 1'b0};
    exp_visits = '{1, 2, 3, 4, 5, 6, 0};

    gen_mode = 1'b0;
    t_len = 1'b0; t_load = '0; t_cs = '0; t_ms_n = '0;
    bus1.flick = 1'b0;
    rst_g = 1'b1;
    repeat (2) tick();
    check("rst_ms", bus1.main_state, 0);
    check("rst_cnt", bus1.counter, 0);
    check("rst_leds", bus1.leds, 0);
    check("rst_tick", bus1.step_tick, 0);
    check("rst_fsync", bus1.flick_sync, 0);
    rst_g = 1'b0;

    for (int i = 0; i < 14; i++) begin
      t_len = vecs[i].len; t_load = vecs[i].load; t_cs = vecs[i].cs; t_ms_n = vecs[i].ms_n;
      tick();
      check($sformatf("vec%0d_ms", i), bus1.main_state, vecs[i].exp_ms);
      check($sformatf("vec%0d_cnt", i), bus1.counter, vecs[i].exp_cnt);
      check($sformatf("vec%0d_leds", i), bus1.leds, vecs[i].exp_leds);
      check($sformatf("vec%0d_kick", i), bus1.kickback_match, vecs[i].exp_kick);
    end
    check("div1_tick_every_cycle", bus1.step_tick, 1);

    // Full sequence with flick released after start.
    rst_g = 1'b1;
    gen_mode = 1'b1;
    repeat (2) tick();
    check("rst2_ms", bus1.main_state, 0);
    rst_g = 1'b0;
    for (int s = 0; s < 8; s++) begin peak[s] = -1; lo[s] = 99; end
    done = 1'b0;
    prev = 0;
    bus1.flick = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c == 3) bus1.flick = 1'b0;
      tick();
      check("seq_leds", bus1.leds, therm(int'(bus1.main_state), int'(bus1.counter)));
      if (int'(bus1.main_state) != prev) begin
        prev = int'(bus1.main_state);
        visits.push_back(prev);
        if (prev == 0) done = 1'b1;
      end
      if (int'(bus1.counter) > peak[bus1.main_state]) peak[bus1.main_state] = int'(bus1.counter);
      if (int'(bus1.counter) < lo[bus1.main_state])   lo[bus1.main_state]   = int'(bus1.counter);
    end
    check("seq_done", done, 1);
    check("seq_nvisits", visits.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("seq_visit%0d", i), (i < visits.size()) ? visits[i] : -1, exp_visits[i]);
    check("seq_peak_s1", peak[1], 16);
    check("seq_peak_s3", peak[3], 11);
    check("seq_peak_s5", peak[5], 6);
    check("seq_low_s2", lo[2], 5);
    check("seq_low_s4", lo[4], 0);
    check("seq_end_cnt", bus1.counter, 0);

    // Kickback in OFFLED15_5 at counter 5.
    start_sequence();
    n = 0;
    while (!(bus1.main_state == 3'd2 && bus1.counter == 5'd7) && n < 100) begin tick(); n++; end
    check("kb1_reach", n < 100, 1);
    bus1.flick = 1'b1;
    n = 0;
    while (!bus1.kickback_match && n < 10) begin tick(); n++; end
    check("kb1_seen", n < 10, 1);
    check("kb1_ms", bus1.main_state, 2);
    check("kb1_cnt", bus1.counter, 5);
    tick();
    check("kb1_next_cnt", bus1.counter, 16);
    check("kb1_next_ms", bus1.main_state, 2);
    bus1.flick = 1'b0;

    // Kickback in OFFLED10_0 at counter 0.
    n = 0;
    while (!(bus1.main_state == 3'd4 && bus1.counter == 5'd2) && n < 200) begin tick(); n++; end
    check("kb2_reach", n < 200, 1);
    bus1.flick = 1'b1;
    n = 0;
    while (!bus1.kickback_match && n < 10) begin tick(); n++; end
    check("kb2_seen", n < 10, 1);
    check("kb2_ms", bus1.main_state, 4);
    check("kb2_cnt", bus1.counter, 0);
    tick();
    check("kb2_next_cnt", bus1.counter, 11);
    check("kb2_next_ms", bus1.main_state, 4);
    bus1.flick = 1'b0;
    n = 0;
    while (bus1.main_state != 3'd0 && n < 200) begin tick(); n++; end
    check("kb2_back_init", n < 200, 1);
    check("kb2_end_cnt", bus1.counter, 0);

    // Reset in the middle of ONLED5_10.
    start_sequence();
    n = 0;
    while (!(bus1.main_state == 3'd3 && bus1.counter == 5'd8) && n < 100) begin tick(); n++; end
    check("mid_rst_reach", n < 100, 1);
    rst_g = 1'b1;
    tick();
    check("mid_rst_ms", bus1.main_state, 0);
    check("mid_rst_cnt", bus1.counter, 0);
    check("mid_rst_leds", bus1.leds, 0);
    check("mid_rst_tick", bus1.step_tick, 0);
    rst_g = 1'b0;
    tick();
    check("post_rst_ms", bus1.main_state, 0);
  endtask

  // Random stimulus on the STEP_DIV=4 instance against a behavioural model.
  task automatic run_rand();
    int   m_ms, m_cnt, m_ticks;
    bit   m_f1, m_fs, m_valid, tick_now;
    logic p_rst, p_flick, p_len;
    logic [4:0] p_load;
    logic [1:0] p_cs;
    logic [2:0] p_ms_n;

    m_valid = 1'b0; m_ms = 0; m_cnt = 0; m_ticks = 0; m_f1 = 0; m_fs = 0;
    p_rst = 1'b1; p_flick = 1'b0; p_len = 1'b0; p_load = '0; p_cs = '0; p_ms_n = '0;
    rst_r = p_rst; bus4.flick = p_flick; bus4.counter_load_en = p_len;
    bus4.counter_load = p_load; bus4.count_state = p_cs; bus4.main_state_n = p_ms_n;

    for (int c = 0; c < 3000; c++) begin
      tick();
      if (p_rst) begin
        m_ms = 0; m_cnt = 0; m_ticks = 0; m_f1 = 0; m_fs = 0; m_valid = 1'b1;
      end else if (m_valid) begin
        tick_now = (m_ticks % SD_R) == (SD_R - 1);
        if (tick_now) begin
          m_ms = int'(p_ms_n);
          if (p_len)           m_cnt = int'(p_load);
          else if (p_cs == 2'd1) m_cnt = (m_cnt + 1 > 31) ? 31 : m_cnt + 1;
          else if (p_cs == 2'd2) m_cnt = (m_cnt - 1 < 0) ? 0 : m_cnt - 1;
        end
        m_ticks++;
        m_fs = m_f1;
        m_f1 = p_flick;
      end

      if (m_valid) begin
        check("rnd_ms", bus4.main_state, m_ms);
        check("rnd_cnt", bus4.counter, m_cnt);
        check("rnd_fsync", bus4.flick_sync, m_fs);
        check("rnd_tick", bus4.step_tick, !p_rst && ((m_ticks % SD_R) == (SD_R - 1)));
        check("rnd_leds", bus4.leds, therm(m_ms, m_cnt));
        check("rnd_kick", bus4.kickback_match,
              m_fs && ((m_ms == 2 && m_cnt == 5) || (m_ms == 4 && m_cnt == 0)));
      end

      p_rst = (c < 2) || ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) p_flick = ~p_flick;
      p_len = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       p_load = 5'd5;
        1:       p_load = 5'd0;
        default: p_load = 5'($urandom_range(0, 31));
      endcase
      p_cs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       p_ms_n = 3'd2;
        1:       p_ms_n = 3'd4;
        default: p_ms_n = 3'($urandom_range(0, 7));
      endcase
      rst_r = p_rst; bus4.flick = p_flick; bus4.counter_load_en = p_len;
      bus4.counter_load = p_load; bus4.count_state = p_cs; bus4.main_state_n = p_ms_n;
    end
  endtask

  initial begin
    gen_mode = 1'b0;
    rst_g = 1'b1;
    rst_r = 1'b1;
    fork
      run_gen();
      run_rand();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
